register_file_writeback: RTL
============================

Name: register_file_writeback

Overview:
- 32x32 RISC-V integer register file; written by the writeback stage, read by decode.
- Write-through bypass plus a pending-write scoreboard.
- Scoreboard entries are set when the decode pipeline register issues an instruction with a destination, and cleared at writeback.
- Raises a stall when decode reads a register whose producer has not yet written back.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- RESET_VALUE, 0, value loaded into every register on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- rs1_sel_in  input  ADDR_WIDTH  decode read index 1
- rs2_sel_in  input  ADDR_WIDTH  decode read index 2
- rs1_value_out  output  DATA_WIDTH  read data 1 (combinational)
- rs2_value_out  output  DATA_WIDTH  read data 2 (combinational)
- issue_enable_in  input  1  decode-register write_enable of the instruction leaving decode
- issue_rd_in  input  ADDR_WIDTH  destination of the issuing instruction
- wb_enable_in  input  1  writeback write strobe
- wb_rd_in  input  ADDR_WIDTH  writeback destination
- wb_data_in  input  DATA_WIDTH  writeback data
- stall_out  output  1  decode must hold (combinational)
- busy_mask_out  output  2**ADDR_WIDTH  registered pending bit per register
- pending_count_out  output  ADDR_WIDTH+1  registered count of pending registers

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - all registers load RESET_VALUE; busy_mask_out=0; pending_count_out=0.
  - wb and issue inputs are ignored in the reset cycle.
  - Reset mid-operation discards all pending state; no partial writes.
- x0 rules:
  - x0 always reads 0.
  - Writes to x0 are dropped.
  - Issue to x0 never sets a pending bit.
  - x0 never causes a stall.
- Read path (combinational, 0 latency):
  - sel==0 -> 0.
  - else wb_enable_in && wb_rd_in==sel -> wb_data_in (write-through bypass).
  - else the array contents.
- Write: at posedge, if !reset && wb_enable_in && wb_rd_in!=0, array[wb_rd_in] <= wb_data_in. Visible in the array from the next cycle, and through the bypass in the same cycle.
- Stall: stall_out = hazard(rs1_sel_in) | hazard(rs2_sel_in), where hazard(s) = s!=0 && busy[s] && !(wb_enable_in && wb_rd_in==s). The same-cycle writeback resolves the hazard through the bypass.
- Scoreboard update at posedge (not reset):
  - set = issue_enable_in && issue_rd_in!=0 && !stall_out
  - clr = wb_enable_in && wb_rd_in!=0
  - Same index for set and clr: set wins, bit ends at 1 (new producer supersedes).
  - Different indices: both apply.
  - Set of an already-pending bit keeps it at 1 (WAW; no error).
  - Clear of a non-pending bit is a no-op.
- Counter: pending_count_out is maintained incrementally (+1 on a 0->1 transition, -1 on a 1->0 transition, net 0 when both occur on different indices). It must always equal popcount(busy_mask_out) and never wrap; the maximum is 31.
- Issue while stall_out=1 is not recorded; decode is held and re-presents the instruction.

Decomposition:
- Shared package rv_pkg: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0.
- One natural sub-module, hazard_scoreboard: busy bits, counter, and stall logic.
- The register array and bypass muxes stay in the top module.

Test Plan:
1. Reset, then read x1..x31 -> all 0; busy_mask_out=0; pending_count_out=0; stall_out=0.
2. wb x5=0xDEADBEEF with rs1_sel_in=5 in the same cycle -> rs1_value_out=0xDEADBEEF that cycle (bypass) and the next cycle (array); wb x0=0x1234 -> x0 still reads 0.
3. Issue rd=7 -> busy[7]=1, count=1. Next cycle rs2_sel_in=7 without wb -> stall_out=1, and an issue with rd=9 in that cycle is not recorded. wb x7=0x55 -> stall_out=0 same cycle, rs2_value_out=0x55, busy[7]=0 next cycle.
4. Simultaneous issue rd=3 and wb rd=3 while busy[3]=1 -> busy[3] stays 1, count unchanged. Simultaneous issue rd=4 and wb rd=3 -> busy[4]=1, busy[3]=0, count unchanged.
5. Issue rd=0 and issue rd=10 twice in a row -> busy[0] never set; busy[10]=1 with count=1 (no double increment).
6. Set busy on 6 registers, assert reset with wb x6 active -> next cycle busy_mask_out=0, count=0, x6 reads 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V integer register file constants.
// Widths, depth and the hard-wired zero register index.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_writeback_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, pending count, stall.
// A same-cycle writeback to a busy source resolves its hazard via bypass.
import rv_pkg::*;

module hazard_scoreboard #(
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      i_rs1_sel,
    input  logic [ADDR_WIDTH-1:0]      i_rs2_sel,
    input  logic                       i_issue_en,
    input  logic [ADDR_WIDTH-1:0]      i_issue_rd,
    input  logic                       i_wb_en,
    input  logic [ADDR_WIDTH-1:0]      i_wb_rd,
    output logic                       o_stall,
    output logic [(1<<ADDR_WIDTH)-1:0] o_busy_mask,
    output logic [ADDR_WIDTH:0]        o_pending_count
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0]  r_busy;
    logic [ADDR_WIDTH:0] r_count;

    logic w_haz1;
    logic w_haz2;
    logic w_set;
    logic w_clr;
    logic w_inc;
    logic w_dec;
    logic [NREGS-1:0] w_busy_next;

    assign w_haz1 = (i_rs1_sel != '0) && r_busy[i_rs1_sel]
                  && !(i_wb_en && (i_wb_rd == i_rs1_sel));
    assign w_haz2 = (i_rs2_sel != '0) && r_busy[i_rs2_sel]
                  && !(i_wb_en && (i_wb_rd == i_rs2_sel));
    assign o_stall = w_haz1 | w_haz2;

    assign w_set = i_issue_en && (i_issue_rd != '0) && !o_stall;
    assign w_clr = i_wb_en && (i_wb_rd != '0);

    // Set wins over clear on the same index: the new producer supersedes.
    assign w_inc = w_set && !r_busy[i_issue_rd];
    assign w_dec = w_clr && r_busy[i_wb_rd]
                 && !(w_set && (i_issue_rd == i_wb_rd));

    always_comb begin
        w_busy_next = r_busy;
        if (w_clr) w_busy_next[i_wb_rd] = 1'b0;
        if (w_set) w_busy_next[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_count <= r_count
                     + {{ADDR_WIDTH{1'b0}}, w_inc}
                     - {{ADDR_WIDTH{1'b0}}, w_dec};
        end
    end

    assign o_busy_mask     = r_busy;
    assign o_pending_count = r_count;

endmodule

// File: rtl/register_file_writeback.sv
// RISC-V integer register file with write-through bypass and
// a pending-write scoreboard that stalls decode on unresolved sources.
import rv_pkg::*;

module register_file_writeback #(
    parameter int                    DATA_WIDTH  = XLEN,
    parameter int                    ADDR_WIDTH  = REG_ADDR_W,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      rs1_sel_in,
    input  logic [ADDR_WIDTH-1:0]      rs2_sel_in,
    output logic [DATA_WIDTH-1:0]      rs1_value_out,
    output logic [DATA_WIDTH-1:0]      rs2_value_out,
    input  logic                       issue_enable_in,
    input  logic [ADDR_WIDTH-1:0]      issue_rd_in,
    input  logic                       wb_enable_in,
    input  logic [ADDR_WIDTH-1:0]      wb_rd_in,
    input  logic [DATA_WIDTH-1:0]      wb_data_in,
    output logic                       stall_out,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_mask_out,
    output logic [ADDR_WIDTH:0]        pending_count_out
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= RESET_VALUE;
        end else if (wb_enable_in && (wb_rd_in != '0)) begin
            r_regs[wb_rd_in] <= wb_data_in;
        end
    end

    always_comb begin
        rs1_value_out = r_regs[rs1_sel_in];
        if (rs1_sel_in == '0)
            rs1_value_out = '0;
        else if (wb_enable_in && (wb_rd_in == rs1_sel_in))
            rs1_value_out = wb_data_in;
    end

    always_comb begin
        rs2_value_out = r_regs[rs2_sel_in];
        if (rs2_sel_in == '0)
            rs2_value_out = '0;
        else if (wb_enable_in && (wb_rd_in == rs2_sel_in))
            rs2_value_out = wb_data_in;
    end

    hazard_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk             (clk),
        .reset           (reset),
        .i_rs1_sel       (rs1_sel_in),
        .i_rs2_sel       (rs2_sel_in),
        .i_issue_en      (issue_enable_in),
        .i_issue_rd      (issue_rd_in),
        .i_wb_en         (wb_enable_in),
        .i_wb_rd         (wb_rd_in),
        .o_stall         (stall_out),
        .o_busy_mask     (busy_mask_out),
        .o_pending_count (pending_count_out)
    );

endmodule
